rom_controller: RTL and testbench



---
 rtl/rom_controller.sv | 173 +++++++++++++++++
 tb/tb_rom_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_controller.sv
// Program ROM controller for the sm510 core: sequences host download,
// holds the CPU in reset until a full image is present, arbitrates the BRAM.
module rom_controller #(
    parameter int ADDR_WIDTH = 12,
    parameter int ROM_BYTES  = 4096,
    parameter int RESET_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic [ADDR_WIDTH-1:0] cpu_rom_addr,
    output logic [7:0]            cpu_rom_data,
    output logic                  cpu_reset,
    input  logic                  dl_active,
    input  logic                  dl_wr,
    input  logic [ADDR_WIDTH:0]   dl_addr,
    input  logic [7:0]            dl_data,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic                  dbg_ack,
    output logic [7:0]            dbg_data,
    output logic                  loaded,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   byte_count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    localparam int HW = $clog2(RESET_HOLD + 1);
    localparam logic [ADDR_WIDTH:0] LP_ROM_BYTES = (ADDR_WIDTH + 1)'(ROM_BYTES);
    localparam logic [HW-1:0] LP_HOLD_LAST = HW'(RESET_HOLD - 2);

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        HOLD,
        RUN
    } state_t;

    state_t              r_state;
    logic [HW-1:0]       r_hold_cnt;
    logic [ADDR_WIDTH:0] r_byte_count;
    logic                r_load_error;
    logic                r_cpu_reset;
    logic                r_loaded;
    logic                r_rd_vld;
    logic                r_rd_dbg;
    logic [7:0]          r_cpu_data;
    logic [7:0]          r_dbg_data;
    logic                r_dbg_ack;

    logic w_load_wr;
    logic w_cpu_rd;
    logic w_dbg_rd;
    logic w_dbg_busy;

    // A debug read is in flight only during the cycle its data sits on mem_rdata
    assign w_dbg_busy = r_rd_vld && r_rd_dbg;

    always_comb begin
        w_load_wr = !reset && (r_state == LOAD) && dl_wr
                    && (dl_addr < LP_ROM_BYTES);
        w_cpu_rd  = !reset && (r_state == RUN) && clk_en;
        w_dbg_rd  = !reset && dbg_req && !w_dbg_busy
                    && !w_load_wr && !w_cpu_rd;
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (w_load_wr) begin
            mem_we    = 1'b1;
            mem_addr  = dl_addr[ADDR_WIDTH-1:0];
            mem_wdata = dl_data;
        end else if (w_cpu_rd) begin
            mem_addr = cpu_rom_addr;
        end else if (w_dbg_rd) begin
            mem_addr = dbg_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_vld   <= 1'b0;
            r_rd_dbg   <= 1'b0;
            r_cpu_data <= '0;
            r_dbg_data <= '0;
            r_dbg_ack  <= 1'b0;
        end else begin
            r_rd_vld  <= w_cpu_rd || w_dbg_rd;
            r_rd_dbg  <= w_dbg_rd;
            r_dbg_ack <= r_rd_vld && r_rd_dbg;
            if (r_rd_vld && !r_rd_dbg) begin
                r_cpu_data <= mem_rdata;
            end
            if (r_rd_vld && r_rd_dbg) begin
                r_dbg_data <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= EMPTY;
            r_hold_cnt   <= '0;
            r_byte_count <= '0;
            r_load_error <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_loaded     <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (dl_active) begin
                        r_state      <= LOAD;
                        r_byte_count <= '0;
                        r_load_error <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_load_wr) begin
                        r_byte_count <= r_byte_count + 1'b1;
                    end
                    if (!dl_active) begin
                        if (r_byte_count == LP_ROM_BYTES) begin
                            r_state    <= HOLD;
                            r_hold_cnt <= '0;
                        end else begin
                            r_state      <= EMPTY;
                            r_load_error <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (dl_active) begin
                        r_state      <= LOAD;
                        r_byte_count <= '0;
                        r_load_error <= 1'b0;
                    end else if (r_hold_cnt == LP_HOLD_LAST) begin
                        r_state     <= RUN;
                        r_cpu_reset <= 1'b0;
                        r_loaded    <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (dl_active) begin
                        r_state      <= LOAD;
                        r_byte_count <= '0;
                        r_load_error <= 1'b0;
                        r_cpu_reset  <= 1'b1;
                        r_loaded     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

    assign cpu_rom_data = r_cpu_data;
    assign cpu_reset    = r_cpu_reset;
    assign dbg_ack      = r_dbg_ack;
    assign dbg_data     = r_dbg_data;
    assign loaded       = r_loaded;
    assign load_error   = r_load_error;
    assign byte_count   = r_byte_count;

endmodule

// File: tb/tb_rom_controller.sv
// Bench for rom_controller: BRAM fixture, shadow ROM image model and
// queue scoreboard for CPU fetch and debug readback returns.
module tb_rom_controller;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic [11:0] cpu_rom_addr;
    logic [7:0]  cpu_rom_data;
    logic        cpu_reset;
    logic        dl_active;
    logic        dl_wr;
    logic [12:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dbg_req;
    logic [11:0] dbg_addr;
    logic        dbg_ack;
    logic [7:0]  dbg_data;
    logic        loaded;
    logic        load_error;
    logic [12:0] byte_count;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    rom_controller dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .cpu_rom_addr (cpu_rom_addr),
        .cpu_rom_data (cpu_rom_data),
        .cpu_reset    (cpu_reset),
        .dl_active    (dl_active),
        .dl_wr        (dl_wr),
        .dl_addr      (dl_addr),
        .dl_data      (dl_data),
        .dbg_req      (dbg_req),
        .dbg_addr     (dbg_addr),
        .dbg_ack      (dbg_ack),
        .dbg_data     (dbg_data),
        .loaded       (loaded),
        .load_error   (load_error),
        .byte_count   (byte_count),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        int         due;
        logic [7:0] val;
    } fetch_t;

    fetch_t     cpu_q[$];
    logic [7:0] dbg_q[$];
    logic [7:0] img[0:4095];
    logic [7:0] bram[0:4095];
    logic [7:0] exp_cpu;
    int         cyc;
    int         checks;
    int         errors;
    fetch_t     ent;
    logic [7:0] dv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial mem_rdata = 8'h00;
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
            ent = cpu_q.pop_front();
            chk("cpu_fetch", {24'h0, cpu_rom_data}, {24'h0, ent.val});
            exp_cpu = ent.val;
        end
        if (dbg_ack === 1'b1) begin
            if (dbg_q.size() == 0) begin
                chk("dbg_spurious_ack", {31'h0, dbg_ack}, 32'h0);
            end else begin
                dv = dbg_q.pop_front();
                chk("dbg_data", {24'h0, dbg_data}, {24'h0, dv});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int n, input int mode);
        int         acc;
        logic [12:0] a;
        logic [7:0]  d;
        acc = 0;
        step();
        clk_en    = 1'b0;
        dl_active = 1'b1;
        step();
        chk("load_entry_count", {19'h0, byte_count}, 32'h0);
        chk("load_entry_error", {31'h0, load_error}, 32'h0);
        chk("load_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        for (int i = 0; i < n; i++) begin
            if (mode == 1 && $urandom_range(0, 15) == 0) begin
                dl_wr   = 1'b1;
                dl_addr = 13'h1000 | 13'($urandom_range(0, 4095));
                dl_data = 8'($urandom);
                clk_en  = 1'($urandom_range(0, 1));
                step();
            end
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
                dl_wr = 1'b0;
                repeat ($urandom_range(1, 2)) step();
            end
            a = (mode == 2) ? 13'(i % 50) : 13'(i);
            d = (mode == 1) ? 8'($urandom) : (a[7:0] ^ 8'h5A);
            dl_wr        = 1'b1;
            dl_addr      = a;
            dl_data      = d;
            clk_en       = 1'($urandom_range(0, 1));
            cpu_rom_addr = 12'($urandom);
            img[a[11:0]] = d;
            acc++;
            step();
        end
        dl_wr  = 1'b0;
        clk_en = 1'b0;
        step();
        chk("load_byte_count", {19'h0, byte_count}, acc);
        chk("load_cpu_data_held", {24'h0, cpu_rom_data}, {24'h0, exp_cpu});
        dl_active = 1'b0;
    endtask

    task automatic wait_run();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (cpu_reset && k < 40);
        chk("hold_cycles", k, 16);
        chk("loaded_in_run", {31'h0, loaded}, 32'h1);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        exp_cpu      = 8'h00;
        reset        = 1'b1;
        clk_en       = 1'b0;
        cpu_rom_addr = '0;
        dl_active    = 1'b0;
        dl_wr        = 1'b0;
        dl_addr      = '0;
        dl_data      = '0;
        dbg_req      = 1'b0;
        dbg_addr     = '0;
        for (int i = 0; i < 4096; i++) bram[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        chk("rst_loaded", {31'h0, loaded}, 32'h0);
        chk("rst_load_error", {31'h0, load_error}, 32'h0);
        chk("rst_byte_count", {19'h0, byte_count}, 32'h0);
        chk("rst_dbg_ack", {31'h0, dbg_ack}, 32'h0);
        chk("rst_cpu_data", {24'h0, cpu_rom_data}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
        reset = 1'b0;

        do_load(4096, 0);
        wait_run();

        for (int j = 0; j < 12; j++) begin
            step();
            clk_en       = (j % 4 == 0);
            cpu_rom_addr = 12'h123;
            if (clk_en) cpu_q.push_back('{cyc + 2, 8'h79});
        end
        step();
        clk_en = 1'b0;
        repeat (3) step();
        chk("fetch_hold", {24'h0, cpu_rom_data}, 32'h79);

        clk_en       = 1'b1;
        cpu_rom_addr = 12'h123;
        dbg_req      = 1'b1;
        dbg_addr     = 12'h010;
        cpu_q.push_back('{cyc + 2, 8'h79});
        dbg_q.push_back(8'h4A);
        #1;
        chk("arb_cpu_first", {20'h0, mem_addr}, 32'h123);
        step();
        clk_en = 1'b0;
        #1;
        chk("arb_dbg_grant", {20'h0, mem_addr}, 32'h010);
        chk("arb_no_early_ack1", {31'h0, dbg_ack}, 32'h0);
        step();
        chk("arb_no_early_ack2", {31'h0, dbg_ack}, 32'h0);
        step();
        chk("arb_ack", {31'h0, dbg_ack}, 32'h1);
        chk("arb_dbg_data", {24'h0, dbg_data}, 32'h4A);
        dbg_req = 1'b0;
        step();
        chk("arb_single_ack", {31'h0, dbg_ack}, 32'h0);
        repeat (2) step();

        do_load(100, 2);
        step();
        chk("short_load_error", {31'h0, load_error}, 32'h1);
        chk("short_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        chk("short_loaded", {31'h0, loaded}, 32'h0);
        repeat (20) step();
        chk("short_stays_reset", {31'h0, cpu_reset}, 32'h1);

        do_load(4096, 1);
        wait_run();

        fork
            begin
                for (int c = 0; c < 400; c++) begin
                    step();
                    clk_en       = 1'($urandom_range(0, 1));
                    cpu_rom_addr = 12'($urandom);
                    if (clk_en) cpu_q.push_back('{cyc + 2, img[cpu_rom_addr]});
                end
                step();
                clk_en = 1'b0;
            end
            begin
                for (int r = 0; r < 30; r++) begin
                    int t;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    dbg_addr = 12'($urandom);
                    dbg_req  = 1'b1;
                    dbg_q.push_back(img[dbg_addr]);
                    t = 0;
                    do begin
                        step();
                        t++;
                    end while (!dbg_ack && t < 64);
                    chk("dbg_ack_seen", {31'h0, dbg_ack}, 32'h1);
                    dbg_req = 1'b0;
                end
            end
        join
        repeat (4) step();
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("dbg_q_drained", dbg_q.size(), 0);

        dl_active = 1'b1;
        step();
        chk("reload_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        chk("reload_loaded", {31'h0, loaded}, 32'h0);
        chk("reload_count_clr", {19'h0, byte_count}, 32'h0);
        dl_wr   = 1'b1;
        dl_addr = 13'h1000;
        dl_data = 8'hFF;
        #1;
        chk("oob_no_we", {31'h0, mem_we}, 32'h0);
        step();
        dl_wr = 1'b0;
        chk("oob_not_counted", {19'h0, byte_count}, 32'h0);

        reset = 1'b1;
        step();
        reset     = 1'b0;
        dl_active = 1'b0;
        chk("mid_rst_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        chk("mid_rst_cpu_data", {24'h0, cpu_rom_data}, 32'h0);
        repeat (3) step();
        chk("mid_rst_stays_empty", {31'h0, loaded}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
